stopwatch_ctrl: RTL and testbench

Sequencing controller for the BCD counter datapath: owns the tick prescaler, runs the multi-digit BCD count under start/stop/clear commands, and exposes packed BCD digits to the display path. It sits between the debounced push-button pulses and the 7-segment decoder. It replaces free-running divided clocks with a single-clock design: the prescaler produces one-cycle enable ticks, and every register runs on `clk`.

---
 rtl/counter_pkg.sv | 11 +
 rtl/tick_gen.sv | 28 ++
 rtl/stopwatch_ctrl.sv | 103 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the stopwatch counter datapath.
package counter_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;
endpackage

// File: rtl/tick_gen.sv
// Enable-gated prescaler: tick is high while enabled and the counter sits at TICK_DIV-1.
// Counter holds its value while en is low; synchronous clr zeroes it and wins over en.
module tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: start/stop/clear FSM, prescaled BCD digit chain, 1-cycle count latency.
// Optional lap hold display snapshot built only when STOPWATCH_LAP_HOLD_EN is defined.
module stopwatch_ctrl
  import counter_pkg::*;
#(
  parameter int TICK_DIV = 500000,
  parameter int DIGITS   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_stop,
  input  logic                    clear,
  input  logic                    lap,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    running,
  output logic                    overflow,
  output logic                    tick
);
  localparam int W = BCD_W * DIGITS;

  sw_state_t state_q, state_d;
  logic      run_en;
  logic [W-1:0]    count_q, count_d;
  logic [DIGITS:0] carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (start_stop) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    run_en  = (state_q == RUN);
    running = run_en;
  end

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run_en),
    .clr   (clear),
    .tick  (tick)
  );

  // Ripple increment: only a digit at exactly 9 carries; any value above 9 just restarts at 0.
  assign carry[0] = tick;
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [BCD_W-1:0] dig;
    assign dig          = count_q[g*BCD_W +: BCD_W];
    assign carry[g+1]   = carry[g] && (dig == BCD_MAX);
    assign count_d[g*BCD_W +: BCD_W] = !carry[g]       ? dig :
                                       (dig >= BCD_MAX) ? '0  : dig + BCD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      count_q <= count_d;
      if (carry[DIGITS]) overflow <= 1'b1;
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic         hold_q;
  logic [W-1:0] snap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
      snap_q <= '0;
    end else if (clear) begin
      hold_q <= 1'b0;
    end else if (lap && (state_q != IDLE)) begin
      hold_q <= !hold_q;
      if (!hold_q) snap_q <= count_q;
    end
  end

  assign bcd = hold_q ? snap_q : count_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign bcd        = count_q;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random commands against a decimal reference model.
module tb_stopwatch_ctrl;
  localparam int TICK_DIV = 4;
  localparam int DIGITS   = 4;
  localparam int W        = 4 * DIGITS;
  localparam int MOD      = 10000;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
`ifdef STOPWATCH_LAP_HOLD_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_stop = 1'b0;
  logic clear = 1'b0;
  logic lap = 1'b0;
  logic [W-1:0] bcd;
  logic running, overflow, tick;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .bcd        (bcd),
    .running    (running),
    .overflow   (overflow),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ticks_seen = 0;

  // Reference model: decimal count value, prescaler phase, mode.
  int m_mode, m_phase, m_count, m_snap;
  bit m_ovf, m_hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit m_tick();
    return (m_mode == M_RUN) && (m_phase == TICK_DIV - 1);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_phase = 0; m_count = 0; m_snap = 0; m_ovf = 0; m_hold = 0;
  endtask

  task automatic model_step(input bit ss, input bit cl, input bit lp);
    bit t;
    t = m_tick();
    if (cl) begin
      m_mode = M_IDLE; m_phase = 0; m_count = 0; m_ovf = 0; m_hold = 0;
      return;
    end
    if (LAP_EN && lp && m_mode != M_IDLE) begin
      m_hold = !m_hold;
      if (m_hold) m_snap = m_count;
    end
    if (t) begin
      if (m_count == MOD - 1) m_ovf = 1;
      m_count = (m_count + 1) % MOD;
    end
    if (m_mode == M_RUN) m_phase = (m_phase + 1) % TICK_DIV;
    if (ss) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
  endtask

  task automatic check_outputs();
    check("bcd", bcd, m_hold ? to_bcd(m_snap) : to_bcd(m_count));
    check("running", running, m_mode == M_RUN);
    check("overflow", overflow, m_ovf);
    check("tick", tick, m_tick());
    if (tick) ticks_seen++;
  endtask

  // Entered and left at a negedge: check, drive, clock, update model, release pulses.
  task automatic do_cycle(input bit ss, input bit cl, input bit lp);
    check_outputs();
    start_stop = ss; clear = cl; lap = lp;
    @(posedge clk);
    model_step(ss, cl, lp);
    @(negedge clk);
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  initial begin
    int n, s;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_bcd", bcd, 0);
    check("rst_running", running, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tick", tick, 0);
    rst_n = 1'b1;

    ticks_seen = 0;
    repeat (20) do_cycle(0, 0, 0);
    check("idle_no_tick", ticks_seen, 0);
    check("idle_bcd", bcd, 16'h0000);

    do_cycle(1, 0, 0);
    check("run_entry", running, 1);
    ticks_seen = 0;
    n = 0;
    while (ticks_seen < 10 && n < 200) begin do_cycle(0, 0, 0); n++; end
    check("tick_period", n, 40);
    check("bcd_10_ticks", bcd, 16'h0010);

    s = ticks_seen; n = 0;
    while (ticks_seen == s && n < 20) begin do_cycle(0, 0, 0); n++; end
    do_cycle(0, 0, 0);
    do_cycle(1, 0, 0);
    repeat (50) do_cycle(0, 0, 0);
    check("paused_bcd", bcd, 16'h0011);
    check("paused_running", running, 0);
    do_cycle(1, 0, 0);
    n = 0;
    while (n < 20) begin
      n++;
      if (tick) break;
      do_cycle(0, 0, 0);
    end
    check("resume_gap", n, 2);

    n = 0;
    while (m_count != 9998 && n < 60000) begin do_cycle(0, 0, 0); n++; end
    check("reach_9998", bcd, 16'h9998);
    check("pre_wrap_ovf", overflow, 0);
    s = ticks_seen; n = 0;
    while (ticks_seen < s + 2 && n < 20) begin do_cycle(0, 0, 0); n++; end
    check("wrap_bcd", bcd, 16'h0000);
    check("wrap_ovf", overflow, 1);
    repeat (10) do_cycle(0, 0, 0);
    check("ovf_sticky", overflow, 1);

    n = 0;
    while (m_count != 123 && n < 2000) begin do_cycle(0, 0, 0); n++; end
    check("reach_0123", bcd, 16'h0123);
    do_cycle(1, 1, 0);
    check("clr_ss_bcd", bcd, 16'h0000);
    check("clr_ss_running", running, 0);
    check("clr_ss_ovf", overflow, 0);
    repeat (6) do_cycle(0, 0, 0);
    check("clr_ss_stays_idle", bcd, 16'h0000);

    do_cycle(1, 0, 0);
    n = 0;
    while (m_count != 5 && n < 100) begin do_cycle(0, 0, 0); n++; end
    do_cycle(0, 0, 1);
    repeat (12) do_cycle(0, 0, 0);
    check("lap_hold", bcd, LAP_EN ? 16'h0005 : 16'h0008);
    do_cycle(0, 0, 1);
    check("lap_release", bcd, 16'h0008);

    do_cycle(0, 1, 0);
    repeat (3000)
      do_cycle($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0);

    do_cycle(0, 1, 0);
    do_cycle(1, 0, 0);
    repeat (9) do_cycle(0, 0, 0);
    check("pre_arst_bcd", bcd, 16'h0002);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bcd", bcd, 0);
    check("arst_running", running, 0);
    check("arst_tick", tick, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) do_cycle(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
